// File: rtl/dac_sample_buffer_pkg.sv
// Shared types and constants for the DAC sample buffer.
// The rounding option is enabled by defining DAC_SAMPLE_BUFFER_ROUND_EN.
package dac_sample_buffer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_FILL = 2'b01,
    ST_RUN  = 2'b10
  } buf_state_e;

  localparam logic [11:0] MIDSCALE_CODE = 12'h800;
  localparam logic [19:0] ROUND_BIAS    = 20'h00080;
  localparam logic [19:0] SAT_MAX       = 20'h7FFFF;

  // Two's-complement MSBs to offset binary: flipping the sign bit re-centres the range.
  function automatic logic [11:0] to_offset_code(input logic [11:0] i_msbs);
    return {~i_msbs[11], i_msbs[10:0]};
  endfunction

endpackage

// File: rtl/dac_sample_buffer_fifo_mem.sv
// Storage for the DAC sample FIFO: DEPTH x WIDTH register array, one write port,
// registered read port whose output register also holds the code between reads.
module sample_fifo_mem
  import dac_sample_buffer_pkg::*;
#(
  parameter int               DEPTH      = 16,
  parameter int               WIDTH      = 12,
  parameter logic [WIDTH-1:0] RESET_DATA = MIDSCALE_CODE
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_wr_en,
  input  logic [$clog2(DEPTH)-1:0] i_wr_addr,
  input  logic [WIDTH-1:0]         i_wr_data,
  input  logic                     i_rd_en,
  input  logic [$clog2(DEPTH)-1:0] i_rd_addr,
  output logic [WIDTH-1:0]         o_rd_data
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [WIDTH-1:0] r_rd_data;

  // Array write; contents need no reset because occupancy gates every read.
  always_ff @(posedge i_clk) begin
    if (i_wr_en) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
  end

  // Read register samples the pre-write contents, so a full-FIFO write+read to one slot is safe.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_rd_data <= RESET_DATA;
    end else if (i_rd_en) begin
      r_rd_data <= r_mem[i_rd_addr];
    end
  end

  assign o_rd_data = r_rd_data;

endmodule

// File: rtl/dac_sample_buffer.sv
// Buffers 20-bit filter samples as 12-bit offset-binary DAC codes with a prime/run FSM.
// Define DAC_SAMPLE_BUFFER_ROUND_EN to round half up (saturating) instead of truncating.
module dac_sample_buffer
  import dac_sample_buffer_pkg::*;
#(
  parameter int DEPTH       = 16,
  parameter int PRIME_LEVEL = 4
) (
  input  logic                     qzt_clk,
  input  logic                     reset,
  input  logic [19:0]              sample_in,
  input  logic                     sample_strobe,
  input  logic                     dac_req,
  output logic [11:0]              dac_code,
  output logic                     dac_valid,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     overflow,
  output logic                     underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_COUNT  = CW'(DEPTH);
  localparam logic [CW-1:0] PRIME_COUNT = CW'(PRIME_LEVEL);

  buf_state_e    r_state;
  buf_state_e    w_state_next;
  logic          r_strobe_d;
  logic          r_req_d;
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic [CW-1:0] w_count_next;
  logic          r_valid;
  logic          r_overflow;
  logic          r_underflow;

  logic          w_strobe_edge;
  logic          w_req_edge;
  logic          w_empty;
  logic          w_full;
  logic          w_rd_req;
  logic          w_rd_en;
  logic          w_wr_en;
  logic          w_underflow_evt;
  logic          w_overflow_evt;
  logic [19:0]   w_s;
  logic [11:0]   w_wr_code;
  logic [11:0]   w_rd_data;
  logic [7:0]    w_unused_lsbs;

`ifdef DAC_SAMPLE_BUFFER_ROUND_EN
  logic [19:0] w_sum;
  assign w_sum = sample_in + ROUND_BIAS;
  // Only a non-negative input can wrap into the sign bit when the bias is added.
  assign w_s   = (!sample_in[19] && w_sum[19]) ? SAT_MAX : w_sum;
`else
  assign w_s   = sample_in;
`endif

  assign w_wr_code     = to_offset_code(w_s[19:8]);
  assign w_unused_lsbs = w_s[7:0];

  assign w_strobe_edge = sample_strobe & ~r_strobe_d;
  assign w_req_edge    = dac_req & ~r_req_d;
  assign w_empty       = (r_count == {CW{1'b0}});
  assign w_full        = (r_count == FULL_COUNT);

  // Read decision precedes write, so an empty FIFO never forwards the incoming sample.
  assign w_rd_req        = w_req_edge && (r_state == ST_RUN);
  assign w_rd_en         = w_rd_req && !w_empty;
  assign w_underflow_evt = w_rd_req && w_empty;
  assign w_wr_en         = w_strobe_edge && (!w_full || w_rd_en);
  assign w_overflow_evt  = w_strobe_edge && w_full && !w_rd_en;

  // Occupancy update.
  always_comb begin
    w_count_next = r_count;
    case ({w_wr_en, w_rd_en})
      2'b10:   w_count_next = r_count + CW'(1);
      2'b01:   w_count_next = r_count - CW'(1);
      default: w_count_next = r_count;
    endcase
  end

  // Next-state logic.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_wr_en) w_state_next = ST_FILL;
        else         w_state_next = ST_IDLE;
      end
      ST_FILL: begin
        if (r_count >= PRIME_COUNT) w_state_next = ST_RUN;
        else                        w_state_next = ST_FILL;
      end
      ST_RUN: begin
        if (w_underflow_evt) w_state_next = ST_FILL;
        else                 w_state_next = ST_RUN;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // Edge-detect copies reset high so a level already asserted at release is ignored.
  always_ff @(posedge qzt_clk or posedge reset) begin
    if (reset) begin
      r_strobe_d <= 1'b1;
      r_req_d    <= 1'b1;
    end else begin
      r_strobe_d <= sample_strobe;
      r_req_d    <= dac_req;
    end
  end

  // FSM state, pointers and occupancy.
  always_ff @(posedge qzt_clk or posedge reset) begin
    if (reset) begin
      r_state  <= ST_IDLE;
      r_wr_ptr <= {AW{1'b0}};
      r_rd_ptr <= {AW{1'b0}};
      r_count  <= {CW{1'b0}};
    end else begin
      r_state <= w_state_next;
      r_count <= w_count_next;
      if (w_wr_en) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_rd_en) r_rd_ptr <= r_rd_ptr + AW'(1);
    end
  end

  // Output qualifier and sticky error flags.
  always_ff @(posedge qzt_clk or posedge reset) begin
    if (reset) begin
      r_valid     <= 1'b0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (w_rd_en)              r_valid <= 1'b1;
      else if (w_underflow_evt) r_valid <= 1'b0;
      if (w_overflow_evt)  r_overflow  <= 1'b1;
      if (w_underflow_evt) r_underflow <= 1'b1;
    end
  end

  sample_fifo_mem #(
    .DEPTH      (DEPTH),
    .WIDTH      (12),
    .RESET_DATA (MIDSCALE_CODE)
  ) u_mem (
    .i_clk     (qzt_clk),
    .i_rst     (reset),
    .i_wr_en   (w_wr_en),
    .i_wr_addr (r_wr_ptr),
    .i_wr_data (w_wr_code),
    .i_rd_en   (w_rd_en),
    .i_rd_addr (r_rd_ptr),
    .o_rd_data (w_rd_data)
  );

  assign dac_code   = w_rd_data;
  assign dac_valid  = r_valid;
  assign fifo_count = r_count;
  assign overflow   = r_overflow;
  assign underflow  = r_underflow;

endmodule

// File: tb/tb_dac_sample_buffer.sv
// Scoreboard bench for dac_sample_buffer: a queue-based reference model predicts the
// state after every strobe/request edge; a negedge monitor compares one cycle later.
module tb_dac_sample_buffer;

  localparam int DEPTH = 16;
  localparam int PRIME = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [19:0] sample_in;
  logic        sample_strobe;
  logic        dac_req;
  logic [11:0] dac_code;
  logic        dac_valid;
  logic [4:0]  fifo_count;
  logic        overflow;
  logic        underflow;

  always #10 clk = ~clk;

  dac_sample_buffer #(.DEPTH(DEPTH), .PRIME_LEVEL(PRIME)) dut (
    .qzt_clk       (clk),
    .reset         (reset),
    .sample_in     (sample_in),
    .sample_strobe (sample_strobe),
    .dac_req       (dac_req),
    .dac_code      (dac_code),
    .dac_valid     (dac_valid),
    .fifo_count    (fifo_count),
    .overflow      (overflow),
    .underflow     (underflow)
  );

  typedef struct {
    int code;
    int valid;
    int count;
    int ovf;
    int unf;
  } exp_t;

  exp_t expq[$];
  int   mq[$];
  int   mstate;   // 0 idle, 1 filling, 2 running
  int   mcode;
  int   mvalid;
  int   movf;
  int   munf;
  int   n_vec = 0;
  int   n_err = 0;

  // Offset-binary code = (signed value + 2^19) / 256, optionally rounded with saturation.
  function automatic int conv(input logic [19:0] s);
    int v;
    v = $signed(s);
`ifdef DAC_SAMPLE_BUFFER_ROUND_EN
    v = v + 128;
    if (v > 524287) v = 524287;
`endif
    return (v + 524288) / 256;
  endfunction

  task automatic chk(input string nm, input int act, input int exp_v);
    n_vec++;
    if (act != exp_v) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp_v, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    expq.delete();
    mstate = 0;
    mcode  = 'h800;
    mvalid = 0;
    movf   = 0;
    munf   = 0;
  endtask

  // One edge event: raise the chosen inputs for a cycle, predict, then leave a quiet gap.
  task automatic do_op(input bit w, input bit r, input logic [19:0] s);
    bit   rd_ok;
    bit   uf;
    bit   wr_ok;
    exp_t e;
    @(posedge clk); #1;
    sample_in     = s;
    sample_strobe = w;
    dac_req       = r;
    rd_ok = r && (mstate == 2) && (mq.size() > 0);
    uf    = r && (mstate == 2) && (mq.size() == 0);
    wr_ok = w && ((mq.size() < DEPTH) || rd_ok);
    if (rd_ok) begin
      mcode  = mq.pop_front();
      mvalid = 1;
    end
    if (uf) begin
      mvalid = 0;
      munf   = 1;
      mstate = 1;
    end
    if (wr_ok) begin
      mq.push_back(conv(s));
      if (mstate == 0) mstate = 1;
    end
    if (w && !wr_ok) movf = 1;
    e.code  = mcode;
    e.valid = mvalid;
    e.count = mq.size();
    e.ovf   = movf;
    e.unf   = munf;
    expq.push_back(e);
    @(posedge clk); #1;
    sample_strobe = 1'b0;
    dac_req       = 1'b0;
    if (mstate == 1 && mq.size() >= PRIME) mstate = 2;
    repeat ($urandom_range(0, 2)) begin
      @(posedge clk); #1;
      sample_in = 20'($urandom());
    end
  endtask

  // Monitor: an input edge seen before a posedge is checked at the following negedge.
  logic prev_s = 1'b1;
  logic prev_r = 1'b1;
  logic pend   = 1'b0;
  exp_t mon_e;
  always @(negedge clk) begin
    if (reset) begin
      prev_s <= 1'b1;
      prev_r <= 1'b1;
      pend   <= 1'b0;
    end else begin
      if (pend) begin
        if (expq.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL monitor: output event with no expectation at %0t", $time);
        end else begin
          mon_e = expq.pop_front();
          chk("dac_code",   int'(dac_code),   mon_e.code);
          chk("dac_valid",  int'(dac_valid),  mon_e.valid);
          chk("fifo_count", int'(fifo_count), mon_e.count);
          chk("overflow",   int'(overflow),   mon_e.ovf);
          chk("underflow",  int'(underflow),  mon_e.unf);
        end
      end
      pend   <= (sample_strobe && !prev_s) || (dac_req && !prev_r);
      prev_s <= sample_strobe;
      prev_r <= dac_req;
    end
  end

  logic [19:0] corner [6];

  initial begin
    corner[0] = 20'h7FFFF;
    corner[1] = 20'h00080;
    corner[2] = 20'h80000;
    corner[3] = 20'h0007F;
    corner[4] = 20'hFFF80;
    corner[5] = 20'h7FF7F;

    reset         = 1'b1;
    sample_strobe = 1'b1;
    dac_req       = 1'b1;
    sample_in     = 20'h00000;
    model_reset();
    #5;
    chk("async_reset_code",  int'(dac_code),   'h800);
    chk("async_reset_count", int'(fifo_count), 0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("release_code",  int'(dac_code),   'h800);
    chk("release_count", int'(fifo_count), 0);
    chk("release_valid", int'(dac_valid),  0);
    chk("release_ovf",   int'(overflow),   0);
    chk("release_unf",   int'(underflow),  0);
    sample_strobe = 1'b0;
    dac_req       = 1'b0;

    // Offset-binary extremes, then read them back once primed
    do_op(1'b1, 1'b0, 20'h7FF00);
    do_op(1'b1, 1'b0, 20'h80000);
    do_op(1'b1, 1'b0, 20'h00000);
    do_op(1'b1, 1'b0, 20'hFFF00);
    repeat (4) do_op(1'b0, 1'b1, 20'h00000);

    // Underflow from empty, then re-prime
    do_op(1'b0, 1'b1, 20'h00000);
    do_op(1'b0, 1'b1, 20'h00000);
    for (int i = 0; i < 4; i++) do_op(1'b1, 1'b0, 20'($urandom()));

    // Fill to DEPTH including rounding corners
    for (int i = 0; i < 12; i++) do_op(1'b1, 1'b0, corner[i % 6]);
    do_op(1'b1, 1'b1, 20'h2A5C3);
    do_op(1'b1, 1'b0, 20'h12345);
    for (int i = 0; i < DEPTH + 1; i++) do_op(1'b0, 1'b1, 20'h00000);

    // Randomised traffic
    for (int i = 0; i < 400; i++) begin
      int pick;
      logic [19:0] s;
      pick = $urandom_range(0, 99);
      s = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 5)] : 20'($urandom());
      if (pick < 45)      do_op(1'b1, 1'b0, s);
      else if (pick < 85) do_op(1'b0, 1'b1, s);
      else if (pick < 95) do_op(1'b1, 1'b1, s);
      else repeat ($urandom_range(1, 4)) @(posedge clk);
    end

    // Asynchronous reset mid-run with both strobes held high
    @(negedge clk); #2;
    reset         = 1'b1;
    sample_strobe = 1'b1;
    dac_req       = 1'b1;
    #1;
    chk("midrun_reset_code",  int'(dac_code),   'h800);
    chk("midrun_reset_count", int'(fifo_count), 0);
    chk("midrun_reset_valid", int'(dac_valid),  0);
    chk("midrun_reset_ovf",   int'(overflow),   0);
    chk("midrun_reset_unf",   int'(underflow),  0);
    model_reset();
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("midrun_release_count", int'(fifo_count), 0);
    chk("midrun_release_code",  int'(dac_code),   'h800);
    sample_strobe = 1'b0;
    dac_req       = 1'b0;
    do_op(1'b0, 1'b1, 20'h00000);
    for (int i = 0; i < 5; i++) do_op(1'b1, 1'b0, 20'($urandom()));
    repeat (3) do_op(1'b0, 1'b1, 20'h00000);

    repeat (3) @(negedge clk);
    chk("expectations_drained", expq.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/dac_sample_buffer.md
DAC_SAMPLE_BUFFER -- requirements
Module: dac_sample_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 16, FIFO entries (power of two, 4..64).
REQ-002 SHALL have parameter PRIME_LEVEL, default 4, occupancy required before streaming starts.
REQ-003 SHALL have ports as listed.
- qzt_clk  in  1  system clock (50 MHz); sole clock.
- reset  in  1  asynchronous, active-high reset.
- sample_in  in  20  signed two's-complement filter output.
- sample_strobe  in  1  new-sample marker, level signal synchronous to qzt_clk; rising edge = sample valid.
- dac_req  in  1  DAC frame-start marker, synchronous to qzt_clk; rising edge = consume one code.
- dac_code  out  12  offset-binary code for DAC channel B.
- dac_valid  out  1  high while dac_code holds a FIFO-sourced sample.
- fifo_count  out  $clog2(DEPTH)+1  current occupancy.
- overflow  out  1  sticky: sample dropped while full.
- underflow  out  1  sticky: dac_req seen while RUN and empty.

Function
REQ-004 SHALL detect edges with one registered copy each of sample_strobe and dac_req: edge = current high AND previous low.
REQ-005 SHALL, on a sample_strobe edge in cycle n, convert sample_in as sampled in cycle n and write it at cycle n+1 if not full.
REQ-006 Conversion SHALL be code = {~s[19], s[18:8]}, where s is sample_in after the optional rounding step (REQ-016).
REQ-007 SHALL drop the write when full with no simultaneous read, set overflow, and leave the FIFO contents unchanged.
REQ-008 SHALL run FSM states IDLE, FILL and RUN, entering IDLE out of reset.
- IDLE -> FILL on the first accepted write.
- FILL -> RUN when fifo_count >= PRIME_LEVEL.
- RUN -> FILL on underflow.
REQ-009 SHALL ignore dac_req edges in IDLE and FILL; dac_code holds its value there.
REQ-010 SHALL, on a dac_req edge in RUN with FIFO non-empty, pop the head at the next cycle, update dac_code at that cycle and hold dac_valid high.
REQ-011 SHALL, on a dac_req edge in RUN with FIFO empty, hold dac_code, drop dac_valid, set underflow and go to FILL.
REQ-012 Simultaneous write and read SHALL both succeed when full (count unchanged); an empty FIFO SHALL never bypass write data to the read side (underflow per REQ-011).
REQ-013 Read and write pointers SHALL wrap modulo DEPTH; fifo_count SHALL range 0..DEPTH exactly.
REQ-014 Sticky flags SHALL clear only on reset.

Reset
REQ-015 reset SHALL asynchronously force the following, and the block SHALL resume at the first qzt_clk edge after deassertion:
- state IDLE, pointers 0, fifo_count 0;
- dac_code 12'h800 (mid-scale), dac_valid 0;
- overflow 0, underflow 0;
- edge-detect registers 1, so a level already high at release is not an edge.

Configuration
REQ-016 With macro DAC_SAMPLE_BUFFER_ROUND_EN defined, s SHALL be sample_in + 20'h00080 saturated to 20'h7FFFF on positive overflow (round half up). Without it, s = sample_in (truncation) and no adder SHALL be synthesized.

Structure
REQ-017 The shared package SHALL hold:
- the FSM state enumeration;
- the MIDSCALE_CODE constant (12'h800);
- the ROUND_BIAS constant (20'h00080).
REQ-018 Storage SHALL be one sub-module, sample_fifo_mem: DEPTH x 12 register array, single write port, registered read.

Verification
REQ-019 Reset release with both strobes high -> no write, no read; dac_code=800h, fifo_count=0.
REQ-020 Four strobe edges with 20'h7FF00, 20'h80000, 20'h00000, 20'hFFF00 -> state RUN after the 4th write. Next four dac_req edges -> dac_code = FFFh, 000h, 800h, 7FFh, each one cycle after its edge.
REQ-021 Seventeen writes with DEPTH=16 and no reads -> fifo_count=16, overflow=1, and the 17th sample is absent from the read sequence.
REQ-022 Full FIFO, sample_strobe and dac_req edges in the same cycle -> fifo_count stays 16, overflow stays 0.
REQ-023 Drain to empty, then one more dac_req edge -> underflow=1, dac_valid=0, dac_code unchanged, state FILL. Four further writes -> RUN again.
REQ-024 With ROUND_EN, sample 20'h7FFFF -> dac_code FFFh (saturated); sample 20'h00080 -> 801h. Without ROUND_EN, the same samples give FFFh and 800h.
